// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: sequences fetch/decode/execute/memory/writeback per opcode.
// Latency: one state per clock; FETCH/MEMRD/MEMWR wait on mem_ready, bounded by TIMEOUT cycles.
// Backpressure: mem_ready low stalls the access; TIMEOUT stalled cycles abort to FETCH with mem_err.
module multicycle_ctrl #(
   parameter int TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       iord,
   output logic       ir_write,
   output logic       pc_en,
   output logic [1:0] pc_src,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic       zero_ext,
   output logic       illegal_op,
   output logic       mem_err,
   output logic [3:0] state
);

   localparam int CW = $clog2(TIMEOUT);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXEC   = 4'd6,
      ALUWB  = 4'd7,
      BRANCH = 4'd8,
      IEXEC  = 4'd9,
      IWB    = 4'd10,
      JUMP   = 4'd11
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            waiting;
   logic            timeout;
   logic            logical_imm;

   assign waiting     = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
   assign timeout     = waiting && !mem_ready && (cnt_q == CW'(TIMEOUT - 1));
   assign logical_imm = (opcode == OP_ANDI) || (opcode == OP_ORI);

   // State and wait-counter registers; reset parks in FETCH with an idle counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FETCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Wait counter: counts stalled cycles; every completion, abort or non-wait state leaves it at zero,
   // so it is always clear on entry to a wait state.
   always_comb begin
      cnt_d = '0;
      if (waiting && !mem_ready && !timeout) cnt_d = cnt_q + CW'(1);
   end

   // Next-state logic; a timeout aborts any memory wait back to FETCH.
   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH:   if (mem_ready) state_d = DECODE;
         DECODE: begin
            case (opcode)
               OP_LW, OP_SW:             state_d = MEMADR;
               OP_RTYPE:                 state_d = EXEC;
               OP_BEQ:                   state_d = BRANCH;
               OP_ADDI, OP_ANDI, OP_ORI: state_d = IEXEC;
               OP_J:                     state_d = JUMP;
               default:                  state_d = FETCH;
            endcase
         end
         MEMADR:  state_d = (opcode == OP_SW) ? MEMWR : (opcode == OP_LW) ? MEMRD : FETCH;
         MEMRD:   if (mem_ready) state_d = MEMWB;
         MEMWB:   state_d = FETCH;
         MEMWR:   if (mem_ready) state_d = FETCH;
         EXEC:    state_d = ALUWB;
         ALUWB:   state_d = FETCH;
         BRANCH:  state_d = FETCH;
         IEXEC:   state_d = IWB;
         IWB:     state_d = FETCH;
         JUMP:    state_d = FETCH;
         default: state_d = FETCH;
      endcase
      if (timeout) state_d = FETCH;
   end

   // Output decode; everything is held at zero while reset is asserted, even mid-access.
   always_comb begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_en      = 1'b0;
      pc_src     = 2'b00;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      zero_ext   = 1'b0;
      illegal_op = 1'b0;
      mem_err    = 1'b0;
      state      = 4'd0;
      if (rst_n) begin
         state   = state_q;
         mem_err = timeout;
         case (state_q)
            FETCH: begin
               mem_req   = 1'b1;
               alu_src_b = 2'b01;
               ir_write  = mem_ready;
               pc_en     = mem_ready;
            end
            DECODE: begin
               alu_src_b = 2'b11;
               case (opcode)
                  OP_LW, OP_SW, OP_RTYPE, OP_BEQ,
                  OP_ADDI, OP_ANDI, OP_ORI, OP_J: illegal_op = 1'b0;
                  default:                        illegal_op = 1'b1;
               endcase
            end
            MEMADR: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
            end
            MEMRD: begin
               mem_req = 1'b1;
               iord    = 1'b1;
            end
            MEMWB: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
            end
            MEMWR: begin
               mem_req = 1'b1;
               mem_we  = 1'b1;
               iord    = 1'b1;
            end
            EXEC: begin
               alu_src_a = 1'b1;
               alu_op    = 2'b10;
            end
            ALUWB: begin
               reg_write = 1'b1;
               reg_dst   = 1'b1;
            end
            BRANCH: begin
               alu_src_a = 1'b1;
               alu_op    = 2'b01;
               pc_src    = 2'b01;
               pc_en     = zero;
            end
            IEXEC: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
               alu_op    = logical_imm ? 2'b11 : 2'b00;
               zero_ext  = logical_imm;
            end
            IWB: begin
               reg_write = 1'b1;
               zero_ext  = logical_imm;
            end
            JUMP: begin
               pc_src = 2'b10;
               pc_en  = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: instruction-route reference model checked every cycle, plus directed scenarios.
// Latency: model follows the DUT state by state; outputs compared on each falling edge.
// Backpressure: mem_ready driven randomly, held low, or raised exactly on the timeout cycle.
module tb_multicycle_ctrl;

   localparam int T = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] opcode = 6'd0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       mem_req, mem_we, iord, ir_write, pc_en, reg_write, reg_dst, mem_to_reg;
   logic       alu_src_a, zero_ext, illegal_op, mem_err;
   logic [1:0] pc_src, alu_src_b, alu_op;
   logic [3:0] state;

   typedef struct packed {
      logic       mem_req, mem_we, iord, ir_write, pc_en;
      logic [1:0] pc_src;
      logic       reg_write, reg_dst, mem_to_reg, alu_src_a;
      logic [1:0] alu_src_b, alu_op;
      logic       zero_ext, illegal_op, mem_err;
      logic [3:0] state;
   } outs_t;

   int    errors = 0;
   int    checks = 0;
   outs_t dut_o, snap;

   multicycle_ctrl #(.TIMEOUT(T)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write), .pc_en(pc_en),
      .pc_src(pc_src), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .zero_ext(zero_ext),
      .illegal_op(illegal_op), .mem_err(mem_err), .state(state)
   );

   assign dut_o = {mem_req, mem_we, iord, ir_write, pc_en, pc_src, reg_write, reg_dst, mem_to_reg,
                   alu_src_a, alu_src_b, alu_op, zero_ext, illegal_op, mem_err, state};

   always #5 clk = ~clk;

   // Reference model: each instruction class walks a fixed route of states; -1 ends the route.
   int route_tbl [7][5] = '{
      '{0, 1, 2, 3, 4},     // lw
      '{0, 1, 2, 5, -1},    // sw
      '{0, 1, 6, 7, -1},    // R-type
      '{0, 1, 8, -1, -1},   // beq
      '{0, 1, 9, 10, -1},   // addi/andi/ori
      '{0, 1, 11, -1, -1},  // j
      '{0, 1, -1, -1, -1}   // illegal
   };
   logic [5:0] legal_ops [8] = '{6'h23, 6'h2b, 6'h00, 6'h04, 6'h08, 6'h0c, 6'h0d, 6'h02};
   int m_pos = 0;
   int m_wait = 0;

   function automatic int cls_of(logic [5:0] op);
      case (op)
         6'h23: return 0;
         6'h2b: return 1;
         6'h00: return 2;
         6'h04: return 3;
         6'h08, 6'h0c, 6'h0d: return 4;
         6'h02: return 5;
         default: return 6;
      endcase
   endfunction

   function automatic int m_state();
      return route_tbl[cls_of(opcode)][m_pos];
   endfunction

   function automatic bit is_wait(int st);
      return st == 0 || st == 3 || st == 5;
   endfunction

   // Advance the model along its route; stalls count toward the timeout abort.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pos  = 0;
         m_wait = 0;
      end else if (is_wait(m_state()) && !mem_ready) begin
         if (m_wait == T - 1) begin
            m_pos  = 0;
            m_wait = 0;
         end else begin
            m_wait = m_wait + 1;
         end
      end else begin
         m_wait = 0;
         m_pos  = m_pos + 1;
         if (m_pos >= 5 || route_tbl[cls_of(opcode)][m_pos] < 0) m_pos = 0;
      end
   end

   function automatic outs_t expect_outs();
      outs_t o;
      int    st;
      bit    lg;
      o  = '0;
      st = m_state();
      lg = (opcode == 6'h0c) || (opcode == 6'h0d);
      if (!rst_n) return o;
      o.state   = 4'(st);
      o.mem_err = is_wait(st) && !mem_ready && (m_wait == T - 1);
      case (st)
         0:  begin o.mem_req = 1; o.alu_src_b = 2'b01; o.ir_write = mem_ready; o.pc_en = mem_ready; end
         1:  begin o.alu_src_b = 2'b11; o.illegal_op = (cls_of(opcode) == 6); end
         2:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
         3:  begin o.mem_req = 1; o.iord = 1; end
         4:  begin o.reg_write = 1; o.mem_to_reg = 1; end
         5:  begin o.mem_req = 1; o.mem_we = 1; o.iord = 1; end
         6:  begin o.alu_src_a = 1; o.alu_op = 2'b10; end
         7:  begin o.reg_write = 1; o.reg_dst = 1; end
         8:  begin o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_src = 2'b01; o.pc_en = zero; end
         9:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_op = lg ? 2'b11 : 2'b00; o.zero_ext = lg; end
         10: begin o.reg_write = 1; o.zero_ext = lg; end
         11: begin o.pc_src = 2'b10; o.pc_en = 1; end
         default: ;
      endcase
      return o;
   endfunction

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison of the whole output bundle against the model.
   always @(negedge clk) begin
      outs_t e;
      e = expect_outs();
      chk("cycle_outputs", int'(dut_o), int'(e));
   end

   // One clock: drive inputs just after the rising edge, snapshot outputs mid-cycle.
   task automatic step(logic [5:0] op, logic z, logic rdy);
      opcode    = op;
      zero      = z;
      mem_ready = rdy;
      @(negedge clk);
      snap = dut_o;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      mem_ready = 1'b0;
      zero      = 1'b0;
      @(negedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [5:0] cur_op;
      int         mode;
      logic       rdy;
      int         lw_st [8] = '{0, 0, 0, 1, 2, 3, 4, 0};
      logic       lw_rd [8] = '{0, 0, 1, 0, 0, 1, 0, 0};

      do_reset();
      // Reset state then lw with mem_ready on the 3rd FETCH cycle and 1st MEMRD cycle.
      for (int i = 0; i < 8; i++) begin
         step(6'h23, 1'b0, lw_rd[i]);
         chk("lw_state", snap.state, lw_st[i]);
         chk("lw_pc_en", snap.pc_en, (i == 2) ? 1 : 0);
         chk("lw_ir_write", snap.ir_write, (i == 2) ? 1 : 0);
         chk("lw_reg_write", snap.reg_write, (i == 6) ? 1 : 0);
      end
      chk("fetch_mem_req", snap.mem_req, 1);

      // beq taken, then not taken.
      for (int z = 1; z >= 0; z--) begin
         do_reset();
         step(6'h04, 1'(z), 1'b1);
         step(6'h04, 1'(z), 1'b0);
         step(6'h04, 1'(z), 1'b0);
         chk("beq_state", snap.state, 8);
         chk("beq_pc_en", snap.pc_en, z);
         chk("beq_pc_src", snap.pc_src, 1);
         step(6'h04, 1'(z), 1'b0);
         chk("beq_return", snap.state, 0);
      end

      // andi then addi through IEXEC/IWB.
      do_reset();
      step(6'h0c, 1'b0, 1'b1);
      step(6'h0c, 1'b0, 1'b0);
      step(6'h0c, 1'b0, 1'b0);
      chk("andi_alu_op", snap.alu_op, 3);
      chk("andi_zext", snap.zero_ext, 1);
      step(6'h0c, 1'b0, 1'b0);
      chk("andi_iwb_state", snap.state, 10);
      chk("andi_iwb_regw", snap.reg_write, 1);
      chk("andi_iwb_rdst", snap.reg_dst, 0);
      chk("andi_iwb_zext", snap.zero_ext, 1);
      step(6'h08, 1'b0, 1'b1);
      step(6'h08, 1'b0, 1'b0);
      step(6'h08, 1'b0, 1'b0);
      chk("addi_zext", snap.zero_ext, 0);
      chk("addi_alu_op", snap.alu_op, 0);

      // sw timeout, then sw completing on the would-be timeout cycle.
      for (int k = 0; k < 2; k++) begin
         do_reset();
         step(6'h2b, 1'b0, 1'b1);
         step(6'h2b, 1'b0, 1'b0);
         step(6'h2b, 1'b0, 1'b0);
         for (int c = 1; c <= T; c++) begin
            step(6'h2b, 1'b0, (k == 1 && c == T) ? 1'b1 : 1'b0);
            if (c == T) begin
               chk("sw_state_last", snap.state, 5);
               chk("sw_mem_err", snap.mem_err, (k == 0) ? 1 : 0);
            end else if (c == 1 || c == T - 1) begin
               chk("sw_no_err_early", snap.mem_err, 0);
            end
         end
         step(6'h2b, 1'b0, 1'b0);
         chk("sw_after", snap.state, 0);
         chk("sw_after_err", snap.mem_err, 0);
      end

      // Illegal opcode.
      do_reset();
      step(6'h3f, 1'b0, 1'b1);
      step(6'h3f, 1'b0, 1'b0);
      chk("ill_flag", snap.illegal_op, 1);
      chk("ill_strobes", {snap.reg_write, snap.pc_en, snap.mem_we, snap.ir_write}, 0);
      step(6'h3f, 1'b0, 1'b0);
      chk("ill_next", snap.state, 0);
      chk("ill_once", snap.illegal_op, 0);

      // Asynchronous reset in the middle of MEMRD.
      do_reset();
      step(6'h23, 1'b0, 1'b1);
      step(6'h23, 1'b0, 1'b0);
      step(6'h23, 1'b0, 1'b0);
      #1;
      chk("memrd_state", int'(state), 3);
      chk("memrd_req", int'(mem_req), 1);
      rst_n = 1'b0;
      #1;
      chk("async_zero", int'(dut_o), 0);
      @(negedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(6'h23, 1'b0, 1'b0);
      chk("post_rst_state", snap.state, 0);
      chk("post_rst_req", snap.mem_req, 1);

      // Randomized run checked by the every-cycle compare.
      cur_op = 6'h23;
      mode   = 0;
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 299) == 0) do_reset();
         if (c % 25 == 0) mode = $urandom_range(0, 2);
         if (m_pos == 0)
            cur_op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 7)];
         case (mode)
            0:       rdy = 1'($urandom);
            1:       rdy = ($urandom_range(0, 39) == 0);
            default: rdy = (m_wait == T - 1);
         endcase
         step(cur_op, 1'($urandom), rdy);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum memory-wait cycles per access; legal range >= 2.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 opcode  in  6  instruction[31:26] from instruction register; stable from DECODE until next FETCH.
REQ-005 zero  in  1  ALU zero flag.
REQ-006 mem_ready  in  1  memory handshake; access completes in a cycle where mem_req=1 and mem_ready=1.
REQ-007 mem_req / mem_we / iord  out  1 each  memory request, write enable, address select (0=PC, 1=ALUOut).
REQ-008 ir_write / pc_en  out  1 each  instruction-register load, PC load.
REQ-009 pc_src  out  2  PC source: 00=ALU result, 01=ALUOut (branch target), 10=jump address.
REQ-010 reg_write / reg_dst / mem_to_reg  out  1 each  register-file write, destination select (1=rd, 0=rt), write-data select (1=MDR).
REQ-011 alu_src_a  out  1  0=PC, 1=register A.
REQ-012 alu_src_b  out  2  00=register B, 01=constant 4, 10=extended immediate, 11=extended immediate<<2.
REQ-013 alu_op  out  2  00=add, 01=subtract, 10=use funct field, 11=logical immediate (and/or by opcode).
REQ-014 zero_ext  out  1  immediate extender mode: 1=zero-extend imm[15:0], 0=sign-extend from imm[15].
REQ-015 illegal_op / mem_err  out  1 each  single-cycle error pulses.
REQ-016 state  out  4  current state encoding, for debug.

Function
REQ-017 States/encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, IEXEC=9, IWB=10, JUMP=11; codes 12-15 unreachable and SHALL go to FETCH.
REQ-018 Outputs are Moore decodes of state, except pc_en, ir_write, mem_err and illegal_op, which also depend on inputs as listed; every output not listed for a state is 0.
REQ-019 FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00; ir_write=pc_en=mem_ready; next state DECODE on mem_ready, else hold.
REQ-020 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00; next by opcode: 100011 (lw)/101011 (sw)->MEMADR, 000000->EXEC, 000100 (beq)->BRANCH, 001000 (addi)/001100 (andi)/001101 (ori)->IEXEC, 000010 (j)->JUMP.
REQ-021 DECODE with any other opcode: illegal_op=1 for that cycle; next state FETCH; no register, PC or memory write.
REQ-022 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00, zero_ext=0; next MEMRD for lw, MEMWR for sw.
REQ-023 MEMRD: mem_req=1, iord=1; next MEMWB on mem_ready. MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1; next FETCH.
REQ-024 MEMWR: mem_req=1, mem_we=1, iord=1; next FETCH on mem_ready.
REQ-025 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; next ALUWB. ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0; next FETCH.
REQ-026 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_en=zero; next FETCH.
REQ-027 IEXEC: alu_src_a=1, alu_src_b=10; addi: alu_op=00, zero_ext=0; andi/ori: alu_op=11, zero_ext=1; next IWB.
REQ-028 IWB: reg_write=1, reg_dst=0, mem_to_reg=0, zero_ext held as in IEXEC; next FETCH. JUMP: pc_src=10, pc_en=1; next FETCH.
REQ-029 Wait counter, width clog2(TIMEOUT): cleared on entry to FETCH, MEMRD or MEMWR; increments each cycle in those states while mem_ready=0.
REQ-030 Timeout: a cycle in FETCH/MEMRD/MEMWR with mem_ready=0 and counter=TIMEOUT-1 SHALL pulse mem_err, go to FETCH and clear the counter; no pc_en, ir_write or reg_write results.
REQ-031 mem_ready asserted on the timeout cycle wins: normal completion, no mem_err.
REQ-032 mem_ready outside FETCH/MEMRD/MEMWR is ignored.

Reset
REQ-033 While rst_n=0, state=FETCH, counter=0, and all outputs SHALL be forced to 0 asynchronously, including mid-access.
REQ-034 On the first clk edge after rst_n rises, FETCH decode applies (mem_req=1); no pending access resumes.

Verification
REQ-035 Assert rst_n=0 during MEMRD -> all outputs 0 in the same cycle; after release state=0, mem_req=1.
REQ-036 lw, mem_ready high on 3rd FETCH cycle and 1st MEMRD cycle -> state 0,0,0,1,2,3,4,0; pc_en=ir_write=1 only on the 3rd cycle; reg_write=1 in MEMWB only.
REQ-037 beq with zero=1, then zero=0 -> BRANCH pc_en=1/pc_src=01, then pc_en=0; both return to FETCH.
REQ-038 opcode 001100 (andi) -> IEXEC alu_op=11, zero_ext=1; IWB reg_write=1, reg_dst=0; addi -> zero_ext=0.
REQ-039 TIMEOUT=16, sw with mem_ready held 0 -> mem_err=1 on 16th MEMWR cycle only, then state=0; mem_ready=1 on 16th cycle -> no mem_err.
REQ-040 opcode 111111 -> illegal_op=1 for one DECODE cycle, state 0 next, no write strobes.
